// File: rtl/traceback_engine_pkg.sv
// Shared types for the traceback engine: traceback pointer directions and the
// controller state encoding.
package datatypesPkg;

  typedef enum logic [1:0] {
    Nil      = 2'd0,
    Diagonal = 2'd1,
    Left     = 2'd2,
    Above    = 2'd3
  } direction_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Index width: one spare bit over the minimum so that len itself fits.
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/traceback_engine_if.sv
// Pointer-write, start and step-stream signals between the PE array/consumer
// (master) and the traceback engine (slave).
interface traceback_engine_if
  import datatypesPkg::*;
#(
  parameter int len1 = 5,
  parameter int len2 = 5
) ();
  localparam int RW  = idx_w(len1);
  localparam int CW  = idx_w(len2);
  localparam int SCW = idx_w(len1 + len2);

  logic           wr_en;
  logic [RW-1:0]  wr_row;
  logic [CW-1:0]  wr_col;
  direction_t     wr_pointer;
  logic           start;
  logic [RW-1:0]  start_row;
  logic [CW-1:0]  start_col;
  logic           step_ready;
  logic           busy;
  logic           step_valid;
  direction_t     step_dir;
  logic [RW-1:0]  step_row;
  logic [CW-1:0]  step_col;
  logic           done;
  logic [SCW-1:0] step_count;

  modport master (
    output wr_en, wr_row, wr_col, wr_pointer,
    output start, start_row, start_col, step_ready,
    input  busy, step_valid, step_dir, step_row, step_col, done, step_count
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_pointer,
    input  start, start_row, start_col, step_ready,
    output busy, step_valid, step_dir, step_row, step_col, done, step_count
  );
endinterface

// File: rtl/traceback_engine_pointer_ram.sv
// len1 x len2 pointer store: one write port, one registered read port.
// Out-of-range accesses are dropped on write and read back as Nil.
module pointer_ram
  import datatypesPkg::*;
#(
  parameter int len1 = 5,
  parameter int len2 = 5
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [idx_w(len1)-1:0] wr_row,
  input  logic [idx_w(len2)-1:0] wr_col,
  input  direction_t             wr_data,
  input  logic                   rd_en,
  input  logic [idx_w(len1)-1:0] rd_row,
  input  logic [idx_w(len2)-1:0] rd_col,
  output direction_t             rd_data
);
  localparam int RW    = idx_w(len1);
  localparam int CW    = idx_w(len2);
  localparam int DEPTH = len1 * len2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RW-1:0] ROWS = RW'(len1);
  localparam logic [CW-1:0] COLS = CW'(len2);

  direction_t mem [DEPTH];

  logic          wr_ok, rd_ok;
  logic [AW-1:0] wr_addr, rd_addr;

  assign wr_ok   = wr_en && (wr_row < ROWS) && (wr_col < COLS);
  assign rd_ok   = (rd_row < ROWS) && (rd_col < COLS);
  assign wr_addr = AW'(int'(wr_row) * len2 + int'(wr_col));
  assign rd_addr = AW'(int'(rd_row) * len2 + int'(rd_col));

  // No reset: contents are only meaningful once the PE array has written them.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : Nil;
  end
endmodule

// File: rtl/traceback_engine.sv
// Walks the alignment pointer matrix back from the max-score cell, emitting one
// (direction, row, col) step per accepted handshake until Nil or the matrix edge.
module traceback_engine
  import datatypesPkg::*;
#(
  parameter int len1 = 5,
  parameter int len2 = 5
) (
  input logic               clk,
  input logic               rst,
  traceback_engine_if.slave bus
);
  localparam int RW  = idx_w(len1);
  localparam int CW  = idx_w(len2);
  localparam int SCW = idx_w(len1 + len2);
  localparam logic [SCW-1:0] CNT_MAX = SCW'(len1 + len2 - 1);

  state_t         state;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [SCW-1:0] cnt;
  logic           busy_q, done_q;
  direction_t     rd_data;
  logic           wr_go, rd_en, emit_vld, at_edge;

  assign wr_go = bus.wr_en && !busy_q;
  assign rd_en = (state == READ);

  pointer_ram #(.len1(len1), .len2(len2)) u_ram (
    .clk     (clk),
    .wr_en   (wr_go),
    .wr_row  (bus.wr_row),
    .wr_col  (bus.wr_col),
    .wr_data (bus.wr_pointer),
    .rd_en   (rd_en),
    .rd_row  (row),
    .rd_col  (col),
    .rd_data (rd_data)
  );

  // Step is decoded straight off the state and RAM output registers so the
  // first step lands two cycles after start; both hold while the consumer stalls.
  assign emit_vld = (state == EMIT) && (rd_data != Nil);

  always_comb begin
    at_edge = 1'b1;
    case (rd_data)
      Diagonal: at_edge = (row == '0) || (col == '0);
      Above:    at_edge = (row == '0);
      Left:     at_edge = (col == '0);
      default:  at_edge = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            row    <= bus.start_row;
            col    <= bus.start_col;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= READ;
          end
        end
        READ: state <= EMIT;
        EMIT: begin
          if (rd_data == Nil) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FINISH;
          end else if (bus.step_ready) begin
            if (cnt != CNT_MAX) cnt <= cnt + SCW'(1);
            if (at_edge) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FINISH;
            end else begin
              if (rd_data != Left)  row <= row - RW'(1);
              if (rd_data != Above) col <= col - CW'(1);
              state <= READ;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_valid = emit_vld;
  assign bus.step_dir   = emit_vld ? rd_data : Nil;
  assign bus.step_row   = row;
  assign bus.step_col   = col;
  assign bus.step_count = cnt;
endmodule

// File: tb/tb_traceback_engine.sv
// Directed bench for traceback_engine: hand-computed step sequences, latencies,
// stall, reset and busy-time interference cases on a 5x5 matrix.
module tb_traceback_engine;
  import datatypesPkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traceback_engine_if #(.len1(5), .len2(5)) ifc ();
  traceback_engine #(.len1(5), .len2(5)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int r, input int c, input direction_t d);
    @(negedge clk);
    ifc.wr_en      = 1'b1;
    ifc.wr_row     = 4'(r);
    ifc.wr_col     = 4'(c);
    ifc.wr_pointer = d;
    @(negedge clk);
    ifc.wr_en      = 1'b0;
  endtask

  // Runs one traceback and checks every step, the first-step latency, the done
  // cycle (counted in negedges after the start pulse) and the final count.
  task automatic trace(input string nm, input int sr, input int sc, input int n,
                       input direction_t ed[4], input int er[4], input int ec[4],
                       input int done_cyc, input int stall, input bit poke,
                       input bit same_wr, input direction_t sd);
    int cyc, got, first, stall_left;
    stall_left     = stall;
    ifc.step_ready = (stall == 0);
    @(negedge clk);
    ifc.start     = 1'b1;
    ifc.start_row = 4'(sr);
    ifc.start_col = 4'(sc);
    if (same_wr) begin
      ifc.wr_en      = 1'b1;
      ifc.wr_row     = 4'(sr);
      ifc.wr_col     = 4'(sc);
      ifc.wr_pointer = sd;
    end
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.wr_en = 1'b0;
    chk({nm, ".busy"}, 32'(ifc.busy), 32'd1);
    chk({nm, ".cnt0"}, 32'(ifc.step_count), 32'd0);
    cyc = 0; got = 0; first = -1;
    while (!ifc.done && cyc < 60) begin
      if (poke && cyc == 2) begin
        ifc.start      = 1'b1;
        ifc.start_row  = 4'd3;
        ifc.start_col  = 4'd4;
        ifc.wr_en      = 1'b1;
        ifc.wr_row     = 4'd1;
        ifc.wr_col     = 4'd1;
        ifc.wr_pointer = Left;
      end
      if (poke && cyc == 3) begin
        ifc.start = 1'b0;
        ifc.wr_en = 1'b0;
      end
      if (ifc.step_valid) begin
        if (first < 0) first = cyc;
        if (got < n) begin
          chk({nm, ".dir"}, 32'(ifc.step_dir),   32'(ed[got]));
          chk({nm, ".row"}, 32'(ifc.step_row),   32'(er[got]));
          chk({nm, ".col"}, 32'(ifc.step_col),   32'(ec[got]));
          chk({nm, ".cnt"}, 32'(ifc.step_count), 32'(got));
        end else begin
          chk({nm, ".extra_step"}, 32'(got), 32'(n - 1));
        end
        if (stall_left > 0) stall_left--;
        else begin
          ifc.step_ready = 1'b1;
          got++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk({nm, ".done"},     32'(ifc.done),       32'd1);
    chk({nm, ".done_cyc"}, 32'(cyc),            32'(done_cyc));
    chk({nm, ".first"},    32'(first),          32'd1);
    chk({nm, ".steps"},    32'(got),            32'(n));
    chk({nm, ".count"},    32'(ifc.step_count), 32'(n));
    chk({nm, ".idle"},     32'(ifc.busy),       32'd0);
    @(negedge clk);
    chk({nm, ".done_pulse"}, 32'(ifc.done),       32'd0);
    chk({nm, ".count_hold"}, 32'(ifc.step_count), 32'(n));
  endtask

  initial begin
    ifc.wr_en      = 1'b0;
    ifc.wr_row     = '0;
    ifc.wr_col     = '0;
    ifc.wr_pointer = Nil;
    ifc.start      = 1'b0;
    ifc.start_row  = '0;
    ifc.start_col  = '0;
    ifc.step_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy",  32'(ifc.busy),       32'd0);
    chk("rst.valid", 32'(ifc.step_valid), 32'd0);
    chk("rst.done",  32'(ifc.done),       32'd0);
    chk("rst.dir",   32'(ifc.step_dir),   32'(Nil));
    chk("rst.row",   32'(ifc.step_row),   32'd0);
    chk("rst.col",   32'(ifc.step_col),   32'd0);
    chk("rst.count", 32'(ifc.step_count), 32'd0);
    chk("rst.state", 32'(dut.state),      32'(IDLE));
    rst = 1'b0;

    wr(2, 2, Diagonal); wr(1, 1, Diagonal); wr(0, 0, Nil);
    wr(3, 4, Left); wr(3, 3, Above); wr(2, 3, Diagonal); wr(1, 2, Nil);
    wr(0, 2, Diagonal); wr(3, 0, Nil);
    // out-of-range row must not alias onto a real cell
    wr(5, 0, Left);

    trace("diag", 2, 2, 2, '{Diagonal, Diagonal, Nil, Nil}, '{2, 1, 0, 0}, '{2, 1, 0, 0},
          6, 0, 1'b0, 1'b0, Nil);
    trace("mixed", 3, 4, 3, '{Left, Above, Diagonal, Nil}, '{3, 3, 2, 0}, '{4, 3, 3, 0},
          8, 0, 1'b0, 1'b0, Nil);
    trace("edge", 0, 2, 1, '{Diagonal, Nil, Nil, Nil}, '{0, 0, 0, 0}, '{2, 0, 0, 0},
          2, 0, 1'b0, 1'b0, Nil);
    trace("stall", 2, 2, 2, '{Diagonal, Diagonal, Nil, Nil}, '{2, 1, 0, 0}, '{2, 1, 0, 0},
          11, 5, 1'b0, 1'b0, Nil);
    trace("busy_poke", 2, 2, 2, '{Diagonal, Diagonal, Nil, Nil}, '{2, 1, 0, 0}, '{2, 1, 0, 0},
          6, 0, 1'b1, 1'b0, Nil);
    trace("wr_start", 4, 0, 1, '{Above, Nil, Nil, Nil}, '{4, 0, 0, 0}, '{0, 0, 0, 0},
          4, 0, 1'b0, 1'b1, Above);

    // reset in the middle of a traceback, after the first step was accepted
    @(negedge clk);
    ifc.step_ready = 1'b1;
    ifc.start      = 1'b1;
    ifc.start_row  = 4'd2;
    ifc.start_col  = 4'd2;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid.valid", 32'(ifc.step_valid), 32'd1);
    chk("mid.count", 32'(ifc.step_count), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst.busy",  32'(ifc.busy),       32'd0);
    chk("mid_rst.valid", 32'(ifc.step_valid), 32'd0);
    chk("mid_rst.state", 32'(dut.state),      32'(IDLE));
    chk("mid_rst.count", 32'(ifc.step_count), 32'd0);
    chk("mid_rst.dir",   32'(ifc.step_dir),   32'(Nil));
    @(negedge clk);
    rst = 1'b0;
    trace("rerun", 2, 2, 2, '{Diagonal, Diagonal, Nil, Nil}, '{2, 1, 0, 0}, '{2, 1, 0, 0},
          6, 0, 1'b0, 1'b0, Nil);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traceback_engine.md
TRACEBACK_ENGINE -- requirements
Module: traceback_engine

Interface
REQ-001 Parameter len1, default 5, number of rows (seq1 length).
REQ-002 Parameter len2, default 5, number of columns (seq2 length).
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wr_en  in  1  pointer-write strobe from the PE array.
REQ-006 wr_row  in  $clog2(len1)+1  write row index, 0..len1-1.
REQ-007 wr_col  in  $clog2(len2)+1  write column index, 0..len2-1.
REQ-008 wr_pointer  in  direction  pointer for cell (wr_row, wr_col).
REQ-009 start  in  1  one-cycle pulse; begins traceback.
REQ-010 start_row  in  $clog2(len1)+1  max-score row, sampled with start.
REQ-011 start_col  in  $clog2(len2)+1  max-score column, sampled with start.
REQ-012 step_ready  in  1  consumer accepts the current step.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 step_valid  out  1  step_dir/step_row/step_col are valid.
REQ-015 step_dir  out  direction  pointer of the emitted cell.
REQ-016 step_row  out  $clog2(len1)+1  row of the emitted cell.
REQ-017 step_col  out  $clog2(len2)+1  column of the emitted cell.
REQ-018 done  out  1  one-cycle pulse at traceback end.
REQ-019 step_count  out  $clog2(len1+len2)+1  steps emitted; held after done until next start.

Function
REQ-020 Pointer RAM: len1*len2 entries of direction, one write port, one synchronous read port with 1-cycle read latency.
REQ-021 Write when wr_en=1 and busy=0; writes while busy are ignored; out-of-range indices are ignored.
REQ-022 FSM states: IDLE, READ, EMIT, FINISH.
REQ-023 IDLE: start=1 latches start_row/start_col into the current position, clears step_count, sets busy, and moves to READ; start in any other state is ignored.
REQ-024 READ: issues the RAM read for the current position and moves to EMIT on the next cycle, when the data is available.
REQ-025 EMIT, data=Nil: emit nothing and go to FINISH.
REQ-026 EMIT, data non-Nil: assert step_valid with the data and the current position; hold all step outputs stable while step_ready=0.
REQ-027 On step_valid&&step_ready: increment step_count and compute the next position as follows.
  - Diagonal: row-1, col-1.
  - Above: row-1.
  - Left: col-1.
REQ-028 If that move would make row or col negative, go to FINISH; otherwise go to READ.
REQ-029 FINISH: pulse done for exactly one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-030 Latency: 2 cycles per step with step_ready held high; the first step_valid occurs 2 cycles after start.
REQ-031 A write and a start in the same cycle: the write completes and the start is accepted; that cell's read occurs no earlier than the next cycle.
REQ-032 step_count saturates at len1+len2-1.

Reset
REQ-033 rst forces, regardless of the current state:
  - state to IDLE;
  - busy, step_valid and done to 0;
  - step_dir to Nil;
  - step_row, step_col and step_count to 0.
REQ-034 RAM contents are not reset; reading a cell that was never written after reset is undefined.

Structure
REQ-035 The direction typedef (Nil, Diagonal, Left, Above) and the state enum belong in datatypesPkg.
REQ-036 The pointer RAM is a sub-module, pointer_ram, parameterised by len1 and len2.

Verification
REQ-037 Write (2,2)=Diagonal, (1,1)=Diagonal, (0,0)=Nil; start at (2,2) with step_ready=1.
  - Required: steps Diagonal@(2,2) then Diagonal@(1,1).
  - done follows; step_count=2.
REQ-038 Write (3,4)=Left, (3,3)=Above, (2,3)=Diagonal, (1,2)=Nil; start at (3,4).
  - Required: steps Left@(3,4), Above@(3,3), Diagonal@(2,3).
  - step_count=3.
REQ-039 Write (0,2)=Diagonal; start at (0,2).
  - Required: one step, Diagonal@(0,2); then done with step_count=1 (boundary termination).
REQ-040 Run the REQ-037 case with step_ready low for 5 cycles on the first step.
  - Required: step outputs held stable for those cycles; no extra step_count increment.
REQ-041 Assert rst mid-traceback, after the first step.
  - Required: busy=0, step_valid=0, state IDLE.
  - A following start reruns the traceback correctly.
REQ-042 A start pulse while busy, and wr_en while busy, are both ignored; the traceback output is unchanged.
